cdma_adder_tree: RTL and testbench
==================================

CDMA_ADDER_TREE -- requirements
Module: cdma_adder_tree

Interface
REQ-001 Parameter NUM_PORTS, default AggrCDMAPkg::NUM_PORTS, number of summed ports; any integer >= 2, power of two not required.
REQ-002 Parameter DATA_WIDTH, default AggrCDMAPkg::DATA_WIDTH, width of each encoded word, two's complement.
REQ-003 Derived localparams: LEVELS = $clog2(NUM_PORTS); SUM_WIDTH = DATA_WIDTH + LEVELS + 1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 spreadingChips  input  NUM_PORTS  per-port +1 completion bit (finishes encoder-side two's-complement negation).
REQ-009 encoded  input  NUM_PORTS x DATA_WIDTH  per-port encoded words, packed.
REQ-010 port_mask  input  NUM_PORTS  per-port enable, sampled with the beat; 0 removes both word and chip from the sum.
REQ-011 sum  output  SUM_WIDTH  signed total of the accepted beat.
REQ-012 out_valid  output  1  sum holds a result.
REQ-013 out_ready  input  1  downstream accepts sum this cycle.

Function
REQ-014 A beat is accepted when in_valid & in_ready; a result leaves when out_valid & out_ready.
REQ-015 Per-port term = port_mask[i] ? (sign-extend(encoded[i]) + spreadingChips[i]) : 0, computed at DATA_WIDTH+1 bits.
REQ-016 Ports are zero-padded to 2^LEVELS; padded ports contribute 0.
REQ-017 The tree has LEVELS registered levels; level k (1..LEVELS) holds pair sums of width DATA_WIDTH+1+k, with each operand sign-extended by 1 bit.
REQ-018 Level 1 forms the per-port terms and the first pair sums in a single cycle.
REQ-019 Latency without backpressure is exactly LEVELS cycles from acceptance to out_valid; for NUM_PORTS=2 this is 1 cycle.
REQ-020 Throughput is one beat per cycle while out_ready=1.
REQ-021 Each level carries a valid bit.
REQ-022 Level k loads when it is empty or when level k+1 loads that cycle; the last level loads when it is empty or out_ready=1.
REQ-023 in_ready equals the level-1 load condition and is combinational from out_ready and the valid bits only, never from in_valid.
REQ-024 Bubbles collapse: an empty level accepts data even when downstream is stalled.
REQ-025 With all levels full and out_ready=0, in_ready=0; sum and out_valid hold; no beat is lost or duplicated; order is preserved.
REQ-026 Data registers of a level that does not load hold their value; data registers need not reset, only valid bits do.
REQ-027 Arithmetic never overflows for any inputs, because SUM_WIDTH covers NUM_PORTS x 2^(DATA_WIDTH-1) in magnitude.
REQ-028 An all-zero port_mask yields sum = 0 with normal valid timing.

Reset
REQ-029 While rst=1 at a clock edge, all level valid bits clear, giving out_valid = 0 and in_ready = 1 from the next cycle.
REQ-030 Reset mid-stream discards all in-flight beats; no partial result ever appears.
REQ-031 rst has priority over a simultaneous acceptance; a beat presented in the reset cycle is dropped.
REQ-032 sum is don't-care while out_valid = 0; the bench shall not check it.

Structure
REQ-033 NUM_PORTS, DATA_WIDTH, LOG_CODE_WIDTH and CDMA_CODE_WIDTH come from AggrCDMAPkg.
REQ-034 A SUM_WIDTH helper function and a level-width helper function belong in AggrCDMAPkg.
REQ-035 One sub-module is natural: adder_tree_level, a single elastic level parametrised by input count and operand width, instantiated LEVELS times by generate.
REQ-036 The block contains no hard-coded per-CDMA_CODE_WIDTH branches.

Verification (NUM_PORTS=8, DATA_WIDTH=8 unless stated)
REQ-037 All encoded=0x05, chips=0, mask=0xFF, out_ready=1 -> sum=40 (12 bits) with out_valid exactly 3 cycles after acceptance.
REQ-038 All encoded=0xFC, chips=0xFF, mask=0xFF -> each term -3, sum=-24 (0xFE8).
REQ-039 encoded=0x7F all, chips=0xFF -> sum=+1024, with no wrap; then mask=0x0F, encoded=0x01, chips=0 -> sum=4.
REQ-040 Backpressure: 6 back-to-back beats with values 1..6 (all ports equal), out_ready=0 for cycles 2-8 -> in_ready falls once 3 beats are held, then sums 8,16,...,48 emerge in order with none missing.
REQ-041 Reset mid-stream: rst pulsed 1 cycle with 2 beats in flight -> out_valid=0 next cycle, in_ready=1, and the in-flight results never appear.
REQ-042 NUM_PORTS=5: encoded=0x7F all, chips=0 -> sum=635 (SUM_WIDTH=12) after 3 cycles.

Source files
------------

// File: rtl/cdma_adder_tree_pkg.sv
// Shared CDMA aggregation sizing and width helpers for the adder tree.
// Pure constants and functions; no timing or flow-control behaviour.
package AggrCDMAPkg;

  localparam int LOG_CODE_WIDTH  = 3;
  localparam int CDMA_CODE_WIDTH = 1 << LOG_CODE_WIDTH;
  localparam int NUM_PORTS       = CDMA_CODE_WIDTH;
  localparam int DATA_WIDTH      = 8;

  // Room for NUM_PORTS full-scale words plus the +1 chip completion.
  function automatic int sum_width(input int num_ports, input int data_width);
    return data_width + $clog2(num_ports) + 1;
  endfunction

  // Width of one pair sum after k levels; k=0 is the per-port term.
  function automatic int level_width(input int data_width, input int k);
    return data_width + 1 + k;
  endfunction

endpackage

// File: rtl/cdma_adder_tree_if.sv
// Beat-in / sum-out handshake bundle for cdma_adder_tree.
// Valid/ready on both sides; master is the upstream producer and downstream sink.
interface cdma_adder_tree_if #(
  parameter int NUM_PORTS  = AggrCDMAPkg::NUM_PORTS,
  parameter int DATA_WIDTH = AggrCDMAPkg::DATA_WIDTH
) ();
  localparam int SUM_WIDTH = AggrCDMAPkg::sum_width(NUM_PORTS, DATA_WIDTH);

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_PORTS-1:0]            spreadingChips;
  logic [NUM_PORTS*DATA_WIDTH-1:0] encoded;
  logic [NUM_PORTS-1:0]            port_mask;
  logic [SUM_WIDTH-1:0]            sum;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output in_valid, spreadingChips, encoded, port_mask, out_ready,
    input  in_ready, sum, out_valid
  );

  modport slave (
    input  in_valid, spreadingChips, encoded, port_mask, out_ready,
    output in_ready, sum, out_valid
  );
endinterface

// File: rtl/cdma_adder_tree_level.sv
// One registered elastic level: N_IN signed operands -> N_IN/2 pair sums, 1 cycle.
// Loads when empty or when downstream loads, so bubbles collapse under stall.
module adder_tree_level #(
  parameter int N_IN = 2,
  parameter int IN_W = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_vld,
  output logic                           load,
  input  logic [N_IN*IN_W-1:0]           in_dat,
  output logic                           out_vld,
  input  logic                           down_load,
  output logic [(N_IN/2)*(IN_W+1)-1:0]   out_dat
);
  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_nx;

  always_comb begin
    sum_nx = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_nx[j*OUT_W +: OUT_W] = OUT_W'($signed(in_dat[(2*j)*IN_W +: IN_W]))
                               + OUT_W'($signed(in_dat[(2*j+1)*IN_W +: IN_W]));
    end
  end

  assign load = !out_vld || down_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
    end else if (load) begin
      out_vld <= in_vld;
    end
  end

  // Data has no reset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (load && in_vld) begin
      out_dat <= sum_nx;
    end
  end
endmodule

// File: rtl/cdma_adder_tree.sv
// Masked signed sum of NUM_PORTS CDMA words; LEVELS-cycle latency, 1 beat/cycle.
// Elastic per-level valids: in_ready depends only on out_ready and valid bits.
module cdma_adder_tree #(
  parameter int NUM_PORTS  = AggrCDMAPkg::NUM_PORTS,
  parameter int DATA_WIDTH = AggrCDMAPkg::DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  cdma_adder_tree_if.slave bus
);
  localparam int LEVELS    = $clog2(NUM_PORTS);
  localparam int SUM_WIDTH = AggrCDMAPkg::sum_width(NUM_PORTS, DATA_WIDTH);
  localparam int NPAD      = 1 << LEVELS;
  localparam int TW        = AggrCDMAPkg::level_width(DATA_WIDTH, 0);

  logic [NPAD*TW-1:0] terms;
  logic [LEVELS:0]    vld;
  logic [LEVELS+1:1]  rdy;

  // Masked ports and the zero padding up to NPAD both contribute 0.
  always_comb begin
    terms = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.port_mask[i]) begin
        terms[i*TW +: TW] = TW'($signed(bus.encoded[i*DATA_WIDTH +: DATA_WIDTH]))
                          + TW'(bus.spreadingChips[i]);
      end
    end
  end

  assign vld[0]          = bus.in_valid;
  assign rdy[LEVELS+1]   = bus.out_ready;
  assign bus.in_ready    = rdy[1];
  assign bus.out_valid   = vld[LEVELS];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_IN = NPAD >> (k - 1);
    localparam int IN_W = AggrCDMAPkg::level_width(DATA_WIDTH, k - 1);

    logic [N_IN*IN_W-1:0]         src;
    logic [(N_IN/2)*(IN_W+1)-1:0] dat;

    if (k == 1) begin : g_first
      assign src = terms;
    end else begin : g_next
      assign src = g_lvl[k-1].dat;
    end

    adder_tree_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (vld[k-1]),
      .load      (rdy[k]),
      .in_dat    (src),
      .out_vld   (vld[k]),
      .down_load (rdy[k+1]),
      .out_dat   (dat)
    );
  end

  assign bus.sum = SUM_WIDTH'(g_lvl[LEVELS].dat);
endmodule

// File: tb/tb_cdma_adder_tree.sv
// Scoreboard bench for cdma_adder_tree: 8-port and 5-port instances, 8-bit words.
module tb_cdma_adder_tree;
  localparam int NP  = 8;
  localparam int NPB = 5;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdma_adder_tree_if #(.NUM_PORTS(NP),  .DATA_WIDTH(DW)) ifa ();
  cdma_adder_tree_if #(.NUM_PORTS(NPB), .DATA_WIDTH(DW)) ifb ();

  cdma_adder_tree #(.NUM_PORTS(NP),  .DATA_WIDTH(DW)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cdma_adder_tree #(.NUM_PORTS(NPB), .DATA_WIDTH(DW)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int    expv;
    int    acc;
    int    lat;
    string name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, expv);
    end
  endfunction

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_a: output sum %0d, required no output", int'($signed(ifa.sum)));
      end else begin
        ea = qa.pop_front();
        chk({ea.name, "_sum"}, int'($signed(ifa.sum)), ea.expv);
        if (ea.lat > 0) chk({ea.name, "_lat"}, cyc - ea.acc, ea.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b: output sum %0d, required no output", int'($signed(ifb.sum)));
      end else begin
        eb = qb.pop_front();
        chk({eb.name, "_sum"}, int'($signed(ifb.sum)), eb.expv);
        if (eb.lat > 0) chk({eb.name, "_lat"}, cyc - eb.acc, eb.lat);
      end
    end
  end

  task automatic send_a(input logic [NP*DW-1:0] enc, input logic [NP-1:0] chips,
                        input logic [NP-1:0] mask, input int expv, input int lat,
                        input string nm);
    int n = 0;
    ifa.in_valid = 1'b1;
    ifa.encoded = enc;
    ifa.spreadingChips = chips;
    ifa.port_mask = mask;
    @(negedge clk);
    while (!ifa.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ifa.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready 0, required 1 within 50 cycles", nm);
    end else begin
      qa.push_back('{expv, cyc, lat, nm});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [NPB*DW-1:0] enc, input logic [NPB-1:0] chips,
                        input logic [NPB-1:0] mask, input int expv, input int lat,
                        input string nm);
    int n = 0;
    ifb.in_valid = 1'b1;
    ifb.encoded = enc;
    ifb.spreadingChips = chips;
    ifb.port_mask = mask;
    @(negedge clk);
    while (!ifb.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ifb.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready 0, required 1 within 50 cycles", nm);
    end else begin
      qb.push_back('{expv, cyc, lat, nm});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.encoded = '0; ifa.spreadingChips = '0; ifa.port_mask = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.encoded = '0; ifb.spreadingChips = '0; ifb.port_mask = '0;
    ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(ifa.out_valid), 0);
    chk("reset_in_ready", int'(ifa.in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed sums on the 8-port tree; latency checked on each.
    send_a({NP{8'h05}}, 8'h00, 8'hFF, 40, 3, "all5");
    idle(4);
    send_a({NP{8'hFC}}, 8'hFF, 8'hFF, -24, 3, "neg3");
    send_a({NP{8'h7F}}, 8'hFF, 8'hFF, 1024, 3, "max");
    send_a({NP{8'h01}}, 8'h00, 8'h0F, 4, 3, "mask0f");
    send_a({NP{8'h80}}, 8'h00, 8'hFF, -1024, 3, "min");
    send_a({NP{8'h33}}, 8'hFF, 8'h00, 0, 3, "mask0");
    send_a({8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC}, 8'hA5, 8'hF0, 8, 3, "mixed");
    idle(5);

    // Non-power-of-two port count.
    send_b({NPB{8'h7F}}, 5'h00, 5'h1F, 635, 3, "np5_max");
    send_b({NPB{8'h80}}, 5'h1F, 5'h1F, -635, 3, "np5_min");
    send_b({NPB{8'h7F}}, 5'h10, 5'h10, 128, 3, "np5_top");
    idle(5);

    // Backpressure: 6 back-to-back beats against a 7-cycle stall.
    fork
      begin
        for (int v = 1; v <= 6; v++) send_a({NP{8'(v)}}, 8'h00, 8'hFF, 8 * v, 0, "bp");
        ifa.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", int'(ifa.in_ready), 0);
        chk("bp_out_valid_hold", int'(ifa.out_valid), 1);
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_drained", qa.size(), 0);

    // Reset with two beats in flight and a third presented in the reset cycle.
    ifa.out_ready = 1'b0;
    send_a({NP{8'h02}}, 8'h00, 8'hFF, 16, 0, "rst_x");
    send_a({NP{8'h03}}, 8'h00, 8'hFF, 24, 0, "rst_y");
    ifa.in_valid = 1'b1;
    ifa.encoded = {NP{8'h04}};
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_in_ready", int'(ifa.in_ready), 1);
    ifa.out_ready = 1'b1;
    idle(6);
    send_a({NP{8'h06}}, 8'h00, 8'hFF, 48, 3, "post_rst");
    idle(2);

    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", qa.size() + qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
